// File: rtl/instr_decode.sv
// Decode stage: registers the fetched word, splits it into regread fields and holds LM/SM for LMSM_SLOTS enabled cycles.
// Optional sticky illegal-opcode trap (illegal_instr/illegal_pc) enabled by DECODE_ILLEGAL_TRAP_EN.
module instr_decode #(
   parameter int unsigned LMSM_SLOTS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr_in,
   input  logic [15:0] PC_in,
   input  logic        valid_f,
   input  logic        en_ctrl,
   input  logic        valid_ctrl,
   output logic [2:0]  rega,
   output logic [2:0]  regb,
   output logic [2:0]  regc,
   output logic [5:0]  imm6,
   output logic [8:0]  imm9,
   output logic [2:0]  ccz,
   output logic        regsel,
   output logic [3:0]  opcode_out,
   output logic [15:0] PC_out,
   output logic        valid_d,
   output logic        freeze_req
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,
   output logic        illegal_instr,
   output logic [15:0] illegal_pc
`endif
);

   localparam int unsigned CNT_W = (LMSM_SLOTS > 1) ? $clog2(LMSM_SLOTS) : 1;
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(LMSM_SLOTS - 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_NAND = 4'd2;
   localparam logic [3:0] OP_LLI  = 4'd3;
   localparam logic [3:0] OP_LW   = 4'd4;
   localparam logic [3:0] OP_LM   = 4'd6;
   localparam logic [3:0] OP_SM   = 4'd7;
   localparam logic [3:0] OP_JAL  = 4'd11;
   localparam logic [3:0] OP_JLR  = 4'd12;

   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic [2:0]  rega_nxt, regb_nxt, regc_nxt, ccz_nxt;
   logic [5:0]  imm6_nxt;
   logic [8:0]  imm9_nxt;
   logic        regsel_nxt, valid_nxt, freeze_nxt;
   logic [3:0]  opcode_nxt;
   logic [15:0] pc_nxt;
   logic [3:0]  op;
   logic        op_illegal, op_lmsm, op_writes;
   logic [2:0]  dest;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        illegal_nxt;
   logic [15:0] illegal_pc_nxt;
`endif

   // Pure field decode of the incoming word
   always_comb begin
      op         = instr_in[15:12];
      op_illegal = (op[3:1] == 3'b111);
      op_lmsm    = (op == OP_LM) || (op == OP_SM);
      op_writes  = op inside {OP_ADD, OP_ADDI, OP_NAND, OP_LLI, OP_LW, OP_LM, OP_JAL, OP_JLR};
      case (op)
         OP_ADD, OP_NAND:              dest = instr_in[5:3];
         OP_ADDI:                      dest = instr_in[8:6];
         OP_LLI, OP_LW, OP_JAL, OP_JLR: dest = instr_in[11:9];
         default:                      dest = 3'd0;
      endcase
   end

   // Next-state: flush > stall > hold countdown > run capture
   always_comb begin
      rega_nxt   = rega;
      regb_nxt   = regb;
      regc_nxt   = regc;
      imm6_nxt   = imm6;
      imm9_nxt   = imm9;
      ccz_nxt    = ccz;
      regsel_nxt = regsel;
      opcode_nxt = opcode_out;
      pc_nxt     = PC_out;
      valid_nxt  = valid_d;
      hold_nxt   = hold_cnt;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_nxt    = illegal_instr;
      illegal_pc_nxt = illegal_pc;
`endif
      if (!valid_ctrl) begin
         rega_nxt   = '0;
         regb_nxt   = '0;
         regc_nxt   = '0;
         imm6_nxt   = '0;
         imm9_nxt   = '0;
         ccz_nxt    = '0;
         regsel_nxt = 1'b0;
         opcode_nxt = '0;
         pc_nxt     = '0;
         valid_nxt  = 1'b0;
         hold_nxt   = '0;
      end else if (!en_ctrl) begin
         hold_nxt = hold_cnt;
      end else if (hold_cnt != '0) begin
         hold_nxt = hold_cnt - CNT_W'(1);
      end else begin
         rega_nxt   = '0;
         regb_nxt   = '0;
         regc_nxt   = '0;
         imm6_nxt   = '0;
         imm9_nxt   = '0;
         ccz_nxt    = '0;
         regsel_nxt = 1'b0;
         opcode_nxt = '0;
         pc_nxt     = '0;
         valid_nxt  = 1'b0;
         if (valid_f) begin
            pc_nxt = PC_in;
            if (!op_illegal) begin
               rega_nxt   = instr_in[11:9];
               regb_nxt   = instr_in[8:6];
               regc_nxt   = dest;
               imm6_nxt   = instr_in[5:0];
               imm9_nxt   = instr_in[8:0];
               ccz_nxt    = instr_in[2:0];
               regsel_nxt = op_writes;
               opcode_nxt = op;
               valid_nxt  = 1'b1;
               if (op_lmsm) hold_nxt = HOLD_INIT;
            end
`ifdef DECODE_ILLEGAL_TRAP_EN
            else if (!illegal_instr) begin
               illegal_nxt    = 1'b1;
               illegal_pc_nxt = PC_in;
            end
`endif
         end
      end
      freeze_nxt = (hold_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rega       <= '0;
         regb       <= '0;
         regc       <= '0;
         imm6       <= '0;
         imm9       <= '0;
         ccz        <= '0;
         regsel     <= 1'b0;
         opcode_out <= '0;
         PC_out     <= '0;
         valid_d    <= 1'b0;
         freeze_req <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         rega       <= rega_nxt;
         regb       <= regb_nxt;
         regc       <= regc_nxt;
         imm6       <= imm6_nxt;
         imm9       <= imm9_nxt;
         ccz        <= ccz_nxt;
         regsel     <= regsel_nxt;
         opcode_out <= opcode_nxt;
         PC_out     <= pc_nxt;
         valid_d    <= valid_nxt;
         freeze_req <= freeze_nxt;
         hold_cnt   <= hold_nxt;
      end
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_instr <= 1'b0;
         illegal_pc    <= '0;
      end else begin
         illegal_instr <= illegal_nxt;
         illegal_pc    <= illegal_pc_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: each driven cycle queues its expected outputs, a monitor pops one per edge.
module tb_instr_decode;

   typedef struct packed {
      logic [3:0]  op;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [2:0]  rc;
      logic [5:0]  i6;
      logic [8:0]  i9;
      logic [2:0]  cc;
      logic        rs;
      logic [15:0] pc;
      logic        vd;
      logic        fr;
`ifdef DECODE_ILLEGAL_TRAP_EN
      logic        ill;
      logic [15:0] ipc;
`endif
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, valid_f, en_ctrl, valid_ctrl;
   logic [15:0] instr_in, PC_in;
   logic [2:0]  rega, regb, regc, ccz;
   logic [5:0]  imm6;
   logic [8:0]  imm9;
   logic        regsel, valid_d, freeze_req;
   logic [3:0]  opcode_out;
   logic [15:0] PC_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        illegal_instr;
   logic [15:0] illegal_pc;
   logic        e_ill = 1'b0;
   logic [15:0] e_ipc = 16'h0000;
`endif

   exp_t q_exp[$];
   int   q_id[$];
   int   total = 0;
   int   bad = 0;
   int   step_no = 0;

   instr_decode dut (
      .clk(clk), .rst(rst), .instr_in(instr_in), .PC_in(PC_in), .valid_f(valid_f),
      .en_ctrl(en_ctrl), .valid_ctrl(valid_ctrl), .rega(rega), .regb(regb), .regc(regc),
      .imm6(imm6), .imm9(imm9), .ccz(ccz), .regsel(regsel), .opcode_out(opcode_out),
      .PC_out(PC_out), .valid_d(valid_d), .freeze_req(freeze_req)
`ifdef DECODE_ILLEGAL_TRAP_EN
      , .illegal_instr(illegal_instr), .illegal_pc(illegal_pc)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                               input logic [2:0] rc, input logic [5:0] i6, input logic [8:0] i9,
                               input logic [2:0] cc, input logic rs, input logic [15:0] pc,
                               input logic vd, input logic fr);
      exp_t e;
      e = '0;
      e.op = op; e.ra = ra; e.rb = rb; e.rc = rc; e.i6 = i6; e.i9 = i9;
      e.cc = cc; e.rs = rs; e.pc = pc; e.vd = vd; e.fr = fr;
      return e;
   endfunction

   function automatic exp_t with_fr(input exp_t e, input logic fr);
      exp_t r;
      r = e;
      r.fr = fr;
      return r;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic step(input logic r, input logic vf, input logic en, input logic vc,
                       input logic [15:0] ins, input logic [15:0] pc, input exp_t e);
      rst = r; valid_f = vf; en_ctrl = en; valid_ctrl = vc; instr_in = ins; PC_in = pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.ill = e_ill;
      e.ipc = e_ipc;
`endif
      q_exp.push_back(e);
      q_id.push_back(step_no);
      step_no++;
      @(posedge clk);
      #2;
   endtask

   // Monitor: one presentation per clock edge
   initial begin
      exp_t e, act;
      int   id;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() != 0) begin
            e  = q_exp.pop_front();
            id = q_id.pop_front();
            act = '0;
            act.op = opcode_out; act.ra = rega; act.rb = regb; act.rc = regc;
            act.i6 = imm6; act.i9 = imm9; act.cc = ccz; act.rs = regsel;
            act.pc = PC_out; act.vd = valid_d; act.fr = freeze_req;
`ifdef DECODE_ILLEGAL_TRAP_EN
            act.ill = illegal_instr;
            act.ipc = illegal_pc;
`endif
            total++;
            if (act !== e) begin
               bad++;
               $display("FAIL step%0d outputs got=%h want=%h", id, act, e);
            end
         end
      end
   end

   initial begin
      exp_t z, e_add, e_beq, lm, sm, lm2;
      z     = mk(4'd0, 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
      e_add = mk(4'd0, 3'd1, 3'd2, 3'd3, 6'h18, 9'h098, 3'd0, 1'b1, 16'h0010, 1'b1, 1'b0);
      e_beq = mk(4'd8, 3'd5, 3'd1, 3'd0, 6'h04, 9'h044, 3'd4, 1'b0, 16'h001C, 1'b1, 1'b0);
      lm    = mk(4'd6, 3'd3, 3'd0, 3'd0, 6'h00, 9'h000, 3'd0, 1'b1, 16'h0020, 1'b1, 1'b1);
      sm    = mk(4'd7, 3'd5, 3'd0, 3'd0, 6'h3C, 9'h03C, 3'd4, 1'b0, 16'h0030, 1'b1, 1'b1);
      lm2   = mk(4'd6, 3'd7, 3'd0, 3'd0, 6'h07, 9'h007, 3'd7, 1'b1, 16'h0050, 1'b1, 1'b1);

      // Reset with a live word on the input
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, z);
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, z);
      // Field decode across opcode classes
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0298, 16'h0010, e_add);
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h4A85, 16'h0012,
           mk(4'd4, 3'd5, 3'd2, 3'd5, 6'h05, 9'h085, 3'd5, 1'b1, 16'h0012, 1'b1, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h5A85, 16'h0014,
           mk(4'd5, 3'd5, 3'd2, 3'd0, 6'h05, 9'h085, 3'd5, 1'b0, 16'h0014, 1'b1, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1283, 16'h0016,
           mk(4'd1, 3'd1, 3'd2, 3'd2, 6'h03, 9'h083, 3'd3, 1'b1, 16'h0016, 1'b1, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h2E51, 16'h0018,
           mk(4'd2, 3'd7, 3'd1, 3'd2, 6'h11, 9'h051, 3'd1, 1'b1, 16'h0018, 1'b1, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'hB3FF, 16'h001A,
           mk(4'd11, 3'd1, 3'd7, 3'd1, 6'h3F, 9'h1FF, 3'd7, 1'b1, 16'h001A, 1'b1, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h8A44, 16'h001C, e_beq);
      // Stall outside a hold keeps everything
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h5A85, 16'h0099, e_beq);

      // LM: 8 presentations, freeze for the first 7; input word is ignored during the hold
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h6600, 16'h0020, lm);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0298, 16'h0022, lm);
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0298, 16'h0022, with_fr(lm, 1'b0));
      e_add.pc = 16'h0022;
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0298, 16'h0022, e_add);

      // SM with a 3-cycle stall mid-hold: stalls consume no slots
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h7A3C, 16'h0030, sm);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 16'h2E51, 16'h0032, sm);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 16'h2E51, 16'h0032, sm);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 16'h2E51, 16'h0032, sm);
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h2E51, 16'h0032, with_fr(sm, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h2E51, 16'h0032,
           mk(4'd2, 3'd7, 3'd1, 3'd2, 6'h11, 9'h051, 3'd1, 1'b1, 16'h0032, 1'b1, 1'b0));

      // Flush on cycle 4 of an LM hold, then normal decode
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h6E07, 16'h0050, lm2);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 16'hB3FF, 16'h0052, lm2);
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'hB3FF, 16'h0052, z);
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'hB3FF, 16'h0052,
           mk(4'd11, 3'd1, 3'd7, 3'd1, 6'h3F, 9'h1FF, 3'd7, 1'b1, 16'h0052, 1'b1, 1'b0));

      // Bubble and illegal opcodes
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0298, 16'h0054, z);
`ifdef DECODE_ILLEGAL_TRAP_EN
      e_ill = 1'b1;
      e_ipc = 16'h0040;
`endif
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'hF123, 16'h0040,
           mk(4'd0, 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 3'd0, 1'b0, 16'h0040, 1'b0, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'hE000, 16'h0042,
           mk(4'd0, 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 3'd0, 1'b0, 16'h0042, 1'b0, 1'b0));
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0298, 16'h0044, z);
      e_add.pc = 16'h0044;
      step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0298, 16'h0044, e_add);
`ifdef DECODE_ILLEGAL_TRAP_EN
      e_ill = 1'b0;
      e_ipc = 16'h0000;
`endif
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0298, 16'h0046, z);

      repeat (3) @(posedge clk);
      #2;
      total++;
      if (q_exp.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", q_exp.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage between instruction fetch and regread.
- Registers a 16-bit instruction word and its PC, splits it into register addresses, immediates, condition bits, destination register and writeback select, and presents them to regread.
- For LM/SM it holds the decoded instruction stable for the 8 cycles regread needs to iterate, and freezes fetch during that time.
- Shares the pipeline's common flush (valid_ctrl) and stall (en_ctrl) controls.

Parameters:
- LMSM_SLOTS, 8, number of consecutive enabled cycles an LM/SM word is presented downstream; must match regread's register iteration count.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- instr_in  input  16  instruction word from fetch
- PC_in  input  16  PC of instr_in
- valid_f  input  1  instr_in is a real instruction
- en_ctrl  input  1  0 = stall/freeze pipeline
- valid_ctrl  input  1  0 = flush this stage
- rega  output  3  instr[11:9]
- regb  output  3  instr[8:6]
- regc  output  3  destination register (see Behaviour)
- imm6  output  6  instr[5:0]
- imm9  output  9  instr[8:0]
- ccz  output  3  {instr[2], instr[1:0]} = {complement, C, Z}
- regsel  output  1  instruction writes the register file
- opcode_out  output  4  instr[15:12]
- PC_out  output  16  registered PC_in
- valid_d  output  1  outputs hold a real instruction
- freeze_req  output  1  hold fetch (PC and instr_in must not advance)

Behaviour:
- All outputs registered on posedge clk. Latency is 1 cycle from instr_in to the outputs.
- Reset: every output is 0; internal hold_cnt is 0.
- Priority per edge: rst > !valid_ctrl > !en_ctrl > normal.
- Flush (!valid_ctrl):
  - All field outputs, PC_out, valid_d and freeze_req go to 0.
  - hold_cnt goes to 0. This includes a flush in the middle of an LM/SM hold.
- Stall (valid_ctrl && !en_ctrl): every output and hold_cnt keep their values.
- Normal, HOLD state (hold_cnt != 0):
  - Outputs are unchanged; instr_in is ignored.
  - hold_cnt decrements by 1 on each normal edge.
- Normal, RUN state (hold_cnt == 0):
  - If valid_f=0: bubble. All fields and PC_out are 0, valid_d=0.
  - Otherwise, decode instr_in and set valid_d=1.
- Opcode map: 0 ADD, 1 ADDI, 2 NAND, 3 LLI, 4 LW, 5 SW, 6 LM, 7 SM, 8 BEQ, 9 BLT, 10 BLE, 11 JAL, 12 JLR, 13 JRI, 14/15 illegal.
- regc:
  - opcode 0,2 -> instr[5:3]
  - opcode 1 -> instr[8:6]
  - opcode 3,4,11,12 -> instr[11:9]
  - all others -> 0
- regsel = 1 for opcodes 0,1,2,3,4,6,11,12; 0 otherwise.
- Illegal opcode (14/15): treated as a bubble (valid_d=0, fields 0), PC_out still = PC_in.
- LM/SM (6/7) decoded in RUN:
  - Load hold_cnt = LMSM_SLOTS-1 (7).
  - freeze_req = (hold_cnt != 0), driven from the register, so it goes high the cycle after capture.
  - Regread therefore samples the identical word on 8 enabled edges.
  - freeze_req drops on the edge where hold_cnt reaches 0, letting fetch advance; the next instruction is captured on the following edge.
- An LM/SM held in HOLD is not re-triggered on exit. A back-to-back LM/SM is a new capture from fetch and reloads hold_cnt.
- Stalls during HOLD do not consume slots.
- The hold_cnt width is the minimum needed to hold LMSM_SLOTS-1.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- With the macro defined:
  - Adds output port illegal_instr (1 bit) and output port illegal_pc (16 bits).
  - illegal_instr is sticky: set on the first normal RUN capture of opcode 14/15 with valid_f=1.
  - illegal_pc captures that PC_in; later illegal opcodes do not overwrite it.
  - Both clear only on rst.
- Without the macro: the ports are absent and illegal opcodes are silently bubbled.

Test Plan:
- Reset: rst=1 for 2 cycles with instr_in=16'h1234 -> all outputs 0. Release with ADD instr 16'h0298, PC 16'h0010 -> next cycle opcode_out=0, rega=1, regb=2, regc=3, ccz=0, regsel=1, valid_d=1, PC_out=16'h0010.
- Field decode: LW 16'h4A85 -> regc=5 (rega), regb=2, imm6=6'h05, regsel=1. SW 16'h5A85 -> regc=0, regsel=0. ADDI 16'h1283 -> regc=2.
- LM hold: LM 16'h6600 (imm9=9'h000 pattern varied) with en_ctrl=1 throughout -> freeze_req=1 for exactly 7 cycles, outputs constant for 8 cycles. The following ADD appears on cycle 9 with valid_d=1.
- Stall inside hold: SM captured, en_ctrl=0 for 3 cycles mid-hold -> freeze_req stays high 3 extra cycles (10 total), outputs frozen, total enabled presentations = 8.
- Flush: valid_ctrl=0 during cycle 4 of an LM hold -> next edge all outputs 0, freeze_req=0. The next fetched instruction decodes normally on the following edge.
- Illegal/bubble: valid_f=0 -> valid_d=0. Opcode 15 at PC 16'h0040 -> valid_d=0, PC_out=16'h0040. With DECODE_ILLEGAL_TRAP_EN, illegal_instr=1 and illegal_pc=16'h0040, both persisting after a later illegal at 16'h0042.
